// File: rtl/rr_seq_pkg.sv
// Shared types and helpers for the round-robin sequenced arbiter.
package rr_seq_pkg;

    localparam int unsigned MAX_REQ = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        COMMIT,
        GAP
    } state_t;

    function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
        logic [MAX_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_seq_arbiter_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
module rr_pick #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic                    any,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int unsigned IW = $clog2(NREQ);

    int unsigned j;

    always_comb begin
        any = 1'b0;
        idx = '0;
        j   = 0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            j = (32'(ptr) + i) % NREQ;
            if (!any && req[j]) begin
                any = 1'b1;
                idx = j[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/rr_seq_arbiter.sv
// Round-robin controller sharing one a/b/c-sequenced resource between NREQ requesters.
module rr_seq_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned GAP  = 0,
    parameter int unsigned CNTW = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [NREQ-1:0]         req,
    output logic                    a,
    output logic                    b,
    output logic                    c,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_id,
    output logic [NREQ-1:0]         done,
    output logic                    busy,
    output logic [CNTW-1:0]         txn_cnt
);

    import rr_seq_pkg::*;

    localparam int unsigned IW = $clog2(NREQ);

    state_t          state, state_n;
    logic [3:0]      gap_cnt, gap_n;
    logic [IW-1:0]   ptr;
    logic            pick_any;
    logic [IW-1:0]   pick_idx;
    logic            start;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    // The final GAP cycle may launch the next pick so the idle stretch is exactly GAP cycles.
    always_comb begin
        state_n = state;
        gap_n   = gap_cnt;
        start   = 1'b0;
        case (state)
            IDLE: begin
                if (en && pick_any) begin
                    state_n = ISSUE;
                    start   = 1'b1;
                end
            end
            ISSUE: state_n = COMMIT;
            COMMIT: begin
                if (GAP > 0) begin
                    state_n = rr_seq_pkg::GAP;
                    gap_n   = '0;
                end else if (en && pick_any) begin
                    state_n = ISSUE;
                    start   = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            rr_seq_pkg::GAP: begin
                if (32'(gap_cnt) == GAP - 1) begin
                    if (en && pick_any) begin
                        state_n = ISSUE;
                        start   = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    gap_n = gap_cnt + 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gap_cnt <= '0;
            ptr     <= IW'(NREQ - 1);
            a       <= 1'b0;
            c       <= 1'b0;
            gnt     <= '0;
            gnt_id  <= '0;
            done    <= '0;
            busy    <= 1'b0;
            txn_cnt <= '0;
        end else begin
            state   <= state_n;
            gap_cnt <= gap_n;
            a       <= start;
            c       <= (state == ISSUE);
            gnt     <= start ? NREQ'(onehot(32'(pick_idx))) : '0;
            done    <= (state == ISSUE) ? gnt : '0;
            busy    <= (state_n != IDLE);
            if (start) begin
                ptr    <= pick_idx;
                gnt_id <= pick_idx;
            end
            if (state == ISSUE && txn_cnt != '1)
                txn_cnt <= txn_cnt + CNTW'(1);
        end
    end

    assign b = a;

    ap_a_b:      assert property (@(posedge clk) disable iff (!rst_n) a |-> b);
    ap_a_c:      assert property (@(posedge clk) disable iff (!rst_n) $past(a) |-> c);
    ap_gnt_oh0:  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    ap_c_past_a: assert property (@(posedge clk) disable iff (!rst_n) c |-> $past(a));
    ap_a_gnt:    assert property (@(posedge clk) disable iff (!rst_n) a |-> $onehot(gnt));
    ap_b_eq_a:   assert property (@(posedge clk) disable iff (!rst_n) b == a);

endmodule

// File: tb/tb_rr_seq_arbiter.sv
// Bench for rr_seq_arbiter: three configurations share stimulus, each tracked by a phase-count model.
module tb_rr_seq_arbiter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] req;

    logic       a_o[3], b_o[3], c_o[3], busy_o[3];
    logic [3:0] gnt_o[3], done_o[3];
    logic [1:0] gid_o[3];
    logic [15:0] cnt0, cnt1;
    logic [3:0]  cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    rr_seq_arbiter #(.NREQ(4), .GAP(0), .CNTW(16)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .a(a_o[0]), .b(b_o[0]), .c(c_o[0]), .gnt(gnt_o[0]), .gnt_id(gid_o[0]),
        .done(done_o[0]), .busy(busy_o[0]), .txn_cnt(cnt0));

    rr_seq_arbiter #(.NREQ(4), .GAP(3), .CNTW(16)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .a(a_o[1]), .b(b_o[1]), .c(c_o[1]), .gnt(gnt_o[1]), .gnt_id(gid_o[1]),
        .done(done_o[1]), .busy(busy_o[1]), .txn_cnt(cnt1));

    rr_seq_arbiter #(.NREQ(4), .GAP(0), .CNTW(4)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .a(a_o[2]), .b(b_o[2]), .c(c_o[2]), .gnt(gnt_o[2]), .gnt_id(gid_o[2]),
        .done(done_o[2]), .busy(busy_o[2]), .txn_cnt(cnt2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: phase 0 = free, 1 = issue visible, 2 = commit visible, 3.. = forced idle.
    typedef struct {
        int phase;
        int ptr;
        int id;
        int cnt;
    } mdl_t;

    mdl_t m[3];
    int   gap_of[3] = '{0, 3, 0};
    int   cmax_of[3] = '{65535, 65535, 15};

    function automatic mdl_t step(mdl_t s, logic [3:0] r, logic e, int g, int cmax);
        mdl_t n;
        int   last;
        bit   may;
        n    = s;
        last = 2 + g;
        may  = (s.phase == 0) || (s.phase == last);
        if (may && e && r != 4'd0) begin
            for (int i = 1; i <= 4; i++) begin
                if (r[(s.ptr + i) % 4]) begin
                    n.id = (s.ptr + i) % 4;
                    break;
                end
            end
            n.ptr   = n.id;
            n.phase = 1;
        end else if (may) begin
            n.phase = 0;
        end else begin
            n.phase = s.phase + 1;
        end
        if (n.phase == 2 && n.cnt < cmax)
            n.cnt = n.cnt + 1;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                m[k].phase <= 0;
                m[k].ptr   <= 3;
                m[k].id    <= 0;
                m[k].cnt   <= 0;
            end else begin
                m[k] <= step(m[k], req, en, gap_of[k], cmax_of[k]);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : cmp
        logic       ea, ec;
        logic [3:0] oh;
        logic [31:0] ca;
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                ea = (m[k].phase == 1);
                ec = (m[k].phase == 2);
                oh = 4'(1 << m[k].id);
                ca = (k == 0) ? 32'(cnt0) : (k == 1) ? 32'(cnt1) : 32'(cnt2);
                chk($sformatf("u%0d.a", k),      32'(a_o[k]),    32'(ea));
                chk($sformatf("u%0d.b", k),      32'(b_o[k]),    32'(ea));
                chk($sformatf("u%0d.c", k),      32'(c_o[k]),    32'(ec));
                chk($sformatf("u%0d.gnt", k),    32'(gnt_o[k]),  ea ? 32'(oh) : 32'd0);
                chk($sformatf("u%0d.done", k),   32'(done_o[k]), ec ? 32'(oh) : 32'd0);
                chk($sformatf("u%0d.gnt_id", k), 32'(gid_o[k]),  32'(m[k].id));
                chk($sformatf("u%0d.busy", k),   32'(busy_o[k]), 32'(m[k].phase != 0));
                chk($sformatf("u%0d.txn_cnt", k), ca,            32'(m[k].cnt));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'd0;
        en    = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    int exp_ids[5] = '{0, 1, 2, 3, 0};

    initial begin
        rst_n = 1'b0;
        req   = 4'd0;
        en    = 1'b0;

        // 1: single requester, first transaction latency
        do_reset();
        chk("rst.a", 32'(a_o[0]), 0);
        chk("rst.c", 32'(c_o[0]), 0);
        chk("rst.gnt", 32'(gnt_o[0]), 0);
        chk("rst.busy", 32'(busy_o[0]), 0);
        chk("rst.txn_cnt", 32'(cnt0), 0);
        req = 4'b0100;
        en  = 1'b1;
        tick();
        chk("t1.a", 32'(a_o[0]), 1);
        chk("t1.b", 32'(b_o[0]), 1);
        chk("t1.gnt", 32'(gnt_o[0]), 32'h4);
        tick();
        chk("t1.c", 32'(c_o[0]), 1);
        chk("t1.done", 32'(done_o[0]), 32'h4);
        chk("t1.txn_cnt", 32'(cnt0), 1);
        chk("t1.a_low", 32'(a_o[0]), 0);
        en = 1'b0;
        repeat (6) tick();

        // 2: strict rotation with all requests held
        do_reset();
        req = 4'b1111;
        en  = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("t2.a[%0d]", k), 32'(a_o[0]), 32'(k % 2));
            if (k % 2 == 1)
                chk($sformatf("t2.gnt_id[%0d]", k), 32'(gid_o[0]), 32'(exp_ids[(k - 1) / 2]));
        end
        chk("t2.txn_cnt", 32'(cnt0), 5);
        en  = 1'b0;
        req = 4'd0;
        repeat (6) tick();

        // 3: request withdrawn during ISSUE still commits
        do_reset();
        req = 4'b1010;
        en  = 1'b1;
        tick();
        chk("t3.a", 32'(a_o[0]), 1);
        chk("t3.gnt_id", 32'(gid_o[0]), 1);
        req = 4'b1000;
        tick();
        chk("t3.c", 32'(c_o[0]), 1);
        chk("t3.done", 32'(done_o[0]), 32'h2);
        tick();
        chk("t3.next_a", 32'(a_o[0]), 1);
        chk("t3.next_id", 32'(gid_o[0]), 3);
        en  = 1'b0;
        req = 4'd0;
        repeat (6) tick();

        // 4: GAP=3 instance issues every 5 cycles
        do_reset();
        req = 4'b0001;
        en  = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk($sformatf("t4.a[%0d]", k), 32'(a_o[1]), 32'((k - 1) % 5 == 0));
            chk($sformatf("t4.busy[%0d]", k), 32'(busy_o[1]), 1);
        end
        en  = 1'b0;
        req = 4'd0;
        repeat (8) tick();

        // 5: reset during ISSUE abandons the transaction
        do_reset();
        req = 4'b1111;
        en  = 1'b1;
        tick();
        chk("t5.a_pre", 32'(a_o[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5.a_rst", 32'(a_o[0]), 0);
        chk("t5.b_rst", 32'(b_o[0]), 0);
        chk("t5.gnt_rst", 32'(gnt_o[0]), 0);
        chk("t5.busy_rst", 32'(busy_o[0]), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("t5.c_in_rst", 32'(c_o[0]), 0);
        en    = 1'b0;
        req   = 4'd0;
        rst_n = 1'b1;
        tick();
        chk("t5.c_after", 32'(c_o[0]), 0);
        chk("t5.busy_after", 32'(busy_o[0]), 0);
        repeat (2) tick();

        // 6: counter saturation, then en low blocks new grants
        do_reset();
        req = 4'b1111;
        en  = 1'b1;
        repeat (44) tick();
        chk("t6.txn_cnt_sat", 32'(cnt2), 15);
        chk("t6.txn_cnt_wide", 32'(cnt0), 22);
        en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            for (int u = 0; u < 3; u++)
                chk($sformatf("t6.no_a u%0d[%0d]", u, k), 32'(a_o[u]), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
